// File: rtl/dport_pkg.sv
// Shared constants and helpers for the data-port router: tag width, select encoding
// and the default two-target address map.
package dport_pkg;

    localparam int DPORT_TAG_W = 11;
    // Select index width covers up to four targets plus the error responder slot.
    localparam int DPORT_SEL_W = 3;

    localparam logic [63:0] DPORT_DEF_BASE = {32'h0000_0000, 32'h0000_0000};
    localparam logic [63:0] DPORT_DEF_MASK = {32'h0000_0000, 32'hFFFF_0000};

    // The error responder occupies the index just past the last real target.
    function automatic logic [DPORT_SEL_W-1:0] dport_err_idx(input int num_tgt);
        return num_tgt[DPORT_SEL_W-1:0];
    endfunction

endpackage

// File: rtl/dport_decerr.sv
// Local decode-error responder: acknowledges an accepted unmapped request one
// cycle later, echoing its tag; one response per cycle, back-to-back allowed.
module dport_decerr
    import dport_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_i,
    input  logic [DPORT_TAG_W-1:0] tag_i,
    output logic                   ack_o,
    output logic [DPORT_TAG_W-1:0] tag_o
);

    logic                   valid_q;
    logic [DPORT_TAG_W-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= req_i;
            if (req_i) begin
                tag_q <= tag_i;
            end
        end
    end

    assign ack_o = valid_q;
    assign tag_o = tag_q;

endmodule

// File: rtl/dport_router.sv
// Data-port router: decodes each LSU request to one of NUM_TGT targets (or the
// local error responder), stalls on target switches and full outstanding count,
// and returns responses from the target that owns the outstanding requests.
module dport_router
    import dport_pkg::*;
#(
    parameter int                    NUM_TGT     = 2,
    parameter logic [32*NUM_TGT-1:0] TGT_BASE    = DPORT_DEF_BASE,
    parameter logic [32*NUM_TGT-1:0] TGT_MASK    = DPORT_DEF_MASK,
    parameter int                    DEFAULT_TGT = 1,
    parameter bit                    DECERR_EN   = 1'b0,
    parameter int                    PEND_W      = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [31:0]                    mem_addr_i,
    input  logic [31:0]                    mem_data_wr_i,
    input  logic                           mem_rd_i,
    input  logic [3:0]                     mem_wr_i,
    input  logic                           mem_cacheable_i,
    input  logic [DPORT_TAG_W-1:0]         mem_req_tag_i,
    input  logic                           mem_inv_i,
    input  logic                           mem_wb_i,
    input  logic                           mem_flush_i,
    output logic [31:0]                    mem_data_rd_o,
    output logic                           mem_accept_o,
    output logic                           mem_ack_o,
    output logic                           mem_error_o,
    output logic [DPORT_TAG_W-1:0]         mem_resp_tag_o,
    output logic [32*NUM_TGT-1:0]          tgt_addr_o,
    output logic [32*NUM_TGT-1:0]          tgt_data_wr_o,
    output logic [NUM_TGT-1:0]             tgt_rd_o,
    output logic [4*NUM_TGT-1:0]           tgt_wr_o,
    output logic [NUM_TGT-1:0]             tgt_cacheable_o,
    output logic [DPORT_TAG_W*NUM_TGT-1:0] tgt_req_tag_o,
    output logic [NUM_TGT-1:0]             tgt_inv_o,
    output logic [NUM_TGT-1:0]             tgt_wb_o,
    output logic [NUM_TGT-1:0]             tgt_flush_o,
    input  logic [NUM_TGT-1:0]             tgt_accept_i,
    input  logic [NUM_TGT-1:0]             tgt_ack_i,
    input  logic [NUM_TGT-1:0]             tgt_error_i,
    input  logic [32*NUM_TGT-1:0]          tgt_data_rd_i,
    input  logic [DPORT_TAG_W*NUM_TGT-1:0] tgt_resp_tag_i
);

    localparam logic [DPORT_SEL_W-1:0] ERR_IDX  = dport_err_idx(NUM_TGT);
    localparam logic [DPORT_SEL_W-1:0] DEF_IDX  = DECERR_EN ? ERR_IDX : DPORT_SEL_W'(DEFAULT_TGT);
    localparam logic [PEND_W-1:0]      PEND_MAX = '1;

    logic                   request_w;
    logic [DPORT_SEL_W-1:0] sel_w;
    logic                   sel_accept_w;
    logic                   hold_w;
    logic                   err_req_w;
    logic                   err_ack_w;
    logic [DPORT_TAG_W-1:0] err_tag_w;

    logic [DPORT_SEL_W-1:0] tgt_q, tgt_d;
    logic [PEND_W-1:0]      pend_q, pend_d;

    assign request_w = mem_rd_i | (|mem_wr_i) | mem_inv_i | mem_wb_i | mem_flush_i;

    // Walk from the highest index down so the lowest-index hit has the last word.
    always_comb begin
        sel_w = DEF_IDX;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if ((mem_addr_i & TGT_MASK[32*i +: 32]) == TGT_BASE[32*i +: 32]) begin
                sel_w = DPORT_SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_accept_w = (sel_w == ERR_IDX);
        for (int i = 0; i < NUM_TGT; i++) begin
            if (sel_w == DPORT_SEL_W'(i)) begin
                sel_accept_w = tgt_accept_i[i];
            end
        end
    end

    // Handshake: a request transfers in the cycle where request_w and mem_accept_o
    // are both high; a response transfers in any cycle where mem_ack_o is high
    // (the LSU never back-pressures responses).
    assign hold_w       = ((pend_q != '0) && (sel_w != tgt_q)) || (pend_q == PEND_MAX);
    assign mem_accept_o = request_w & sel_accept_w & ~hold_w;
    assign err_req_w    = mem_accept_o & (sel_w == ERR_IDX);

    for (genvar g = 0; g < NUM_TGT; g++) begin : g_tgt
        logic fwd_w;
        assign fwd_w = (sel_w == DPORT_SEL_W'(g)) & ~hold_w;

        assign tgt_addr_o[32*g +: 32]                    = mem_addr_i;
        assign tgt_data_wr_o[32*g +: 32]                 = mem_data_wr_i;
        assign tgt_cacheable_o[g]                        = mem_cacheable_i;
        assign tgt_req_tag_o[DPORT_TAG_W*g +: DPORT_TAG_W] = mem_req_tag_i;
        assign tgt_rd_o[g]                               = mem_rd_i & fwd_w;
        assign tgt_wr_o[4*g +: 4]                        = mem_wr_i & {4{fwd_w}};
        assign tgt_inv_o[g]                              = mem_inv_i & fwd_w;
        assign tgt_wb_o[g]                               = mem_wb_i & fwd_w;
        assign tgt_flush_o[g]                            = mem_flush_i & fwd_w;
    end

    // Responses follow the registered owner; acks from any other target are dropped.
    always_comb begin
        mem_ack_o      = 1'b0;
        mem_error_o    = 1'b0;
        mem_data_rd_o  = '0;
        mem_resp_tag_o = '0;
        if (tgt_q == ERR_IDX) begin
            mem_ack_o      = err_ack_w;
            mem_error_o    = err_ack_w;
            mem_resp_tag_o = err_tag_w;
        end
        for (int i = 0; i < NUM_TGT; i++) begin
            if (tgt_q == DPORT_SEL_W'(i)) begin
                mem_ack_o      = tgt_ack_i[i];
                mem_error_o    = tgt_error_i[i];
                mem_data_rd_o  = tgt_data_rd_i[32*i +: 32];
                mem_resp_tag_o = tgt_resp_tag_i[DPORT_TAG_W*i +: DPORT_TAG_W];
            end
        end
    end

    always_comb begin
        tgt_d  = mem_accept_o ? sel_w : tgt_q;
        pend_d = pend_q;
        if (mem_accept_o && !mem_ack_o) begin
            pend_d = pend_q + 1'b1;
        end else if (!mem_accept_o && mem_ack_o && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q  <= '0;
            pend_q <= '0;
        end else begin
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
        end
    end

    dport_decerr u_decerr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (err_req_w),
        .tag_i (mem_req_tag_i),
        .ack_o (err_ack_w),
        .tag_o (err_tag_w)
    );

endmodule

// File: tb/tb_dport_router.sv
// Bench for dport_router: a default two-target instance and a three-target
// instance with the error responder and a 2-bit outstanding counter.
module tb_dport_router;
  import dport_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  // shared request fields, per-instance request strobes
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [10:0] tag_i = '0;
  logic        rd_a = 1'b0, rd_b = 1'b0;
  logic [3:0]  wr_a = '0, wr_b = '0;

  // instance A outputs / target side
  logic [31:0] a_data;
  logic        a_accept, a_ack, a_error;
  logic [10:0] a_rtag;
  logic [63:0] a_tgt_addr, a_tgt_wdata, a_tgt_rdata;
  logic [1:0]  a_tgt_rd, a_tgt_cache, a_tgt_inv, a_tgt_wb, a_tgt_flush;
  logic [7:0]  a_tgt_wr;
  logic [21:0] a_tgt_reqtag, a_tgt_rtag;
  logic [1:0]  a_tgt_accept = 2'b11;
  logic [1:0]  a_tgt_ack, a_tgt_err;

  // instance B outputs / target side
  logic [31:0] b_data;
  logic        b_accept, b_ack, b_error;
  logic [10:0] b_rtag;
  logic [95:0] b_tgt_addr, b_tgt_wdata, b_tgt_rdata;
  logic [2:0]  b_tgt_rd, b_tgt_cache, b_tgt_inv, b_tgt_wb, b_tgt_flush;
  logic [11:0] b_tgt_wr;
  logic [32:0] b_tgt_reqtag, b_tgt_rtag;
  logic [2:0]  b_tgt_accept = 3'b111;
  logic [2:0]  b_tgt_ack, b_tgt_err;

  dport_router dut_a (
    .clk(clk), .rst_n(rst_n),
    .mem_addr_i(addr_i), .mem_data_wr_i(wdata_i), .mem_rd_i(rd_a), .mem_wr_i(wr_a),
    .mem_cacheable_i(1'b1), .mem_req_tag_i(tag_i),
    .mem_inv_i(1'b0), .mem_wb_i(1'b0), .mem_flush_i(1'b0),
    .mem_data_rd_o(a_data), .mem_accept_o(a_accept), .mem_ack_o(a_ack),
    .mem_error_o(a_error), .mem_resp_tag_o(a_rtag),
    .tgt_addr_o(a_tgt_addr), .tgt_data_wr_o(a_tgt_wdata), .tgt_rd_o(a_tgt_rd),
    .tgt_wr_o(a_tgt_wr), .tgt_cacheable_o(a_tgt_cache), .tgt_req_tag_o(a_tgt_reqtag),
    .tgt_inv_o(a_tgt_inv), .tgt_wb_o(a_tgt_wb), .tgt_flush_o(a_tgt_flush),
    .tgt_accept_i(a_tgt_accept), .tgt_ack_i(a_tgt_ack), .tgt_error_i(a_tgt_err),
    .tgt_data_rd_i(a_tgt_rdata), .tgt_resp_tag_i(a_tgt_rtag)
  );

  dport_router #(
    .NUM_TGT(3),
    .TGT_BASE({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .TGT_MASK({32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000}),
    .DEFAULT_TGT(0), .DECERR_EN(1'b1), .PEND_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .mem_addr_i(addr_i), .mem_data_wr_i(wdata_i), .mem_rd_i(rd_b), .mem_wr_i(wr_b),
    .mem_cacheable_i(1'b0), .mem_req_tag_i(tag_i),
    .mem_inv_i(1'b0), .mem_wb_i(1'b0), .mem_flush_i(1'b0),
    .mem_data_rd_o(b_data), .mem_accept_o(b_accept), .mem_ack_o(b_ack),
    .mem_error_o(b_error), .mem_resp_tag_o(b_rtag),
    .tgt_addr_o(b_tgt_addr), .tgt_data_wr_o(b_tgt_wdata), .tgt_rd_o(b_tgt_rd),
    .tgt_wr_o(b_tgt_wr), .tgt_cacheable_o(b_tgt_cache), .tgt_req_tag_o(b_tgt_reqtag),
    .tgt_inv_o(b_tgt_inv), .tgt_wb_o(b_tgt_wb), .tgt_flush_o(b_tgt_flush),
    .tgt_accept_i(b_tgt_accept), .tgt_ack_i(b_tgt_ack), .tgt_error_i(b_tgt_err),
    .tgt_data_rd_i(b_tgt_rdata), .tgt_resp_tag_i(b_tgt_rtag)
  );

  // ---------------- target models ----------------
  // Each target answers in order, dly cycles after accept, returning addr ^ key.
  typedef struct { int due; logic [10:0] tag; logic [31:0] addr; } ent_t;
  int dly_a = 1, dly_b = 1;
  bit stall_a = 1'b0, stall_b = 1'b0;

  function automatic logic [31:0] tgt_key(input int t);
    return 32'h1111_1111 * (t + 1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_ra
    ent_t q[$];
    logic ack_r = 1'b0;
    logic [31:0] data_r = '0;
    logic [10:0] tag_r = '0;
    assign a_tgt_ack[g] = ack_r;
    assign a_tgt_err[g] = 1'b0;
    assign a_tgt_rdata[32*g +: 32] = data_r;
    assign a_tgt_rtag[11*g +: 11] = tag_r;
    always @(negedge clk) begin
      if (!rst_n) q.delete();
      else begin
        if (ack_r) void'(q.pop_front());
        if ((a_tgt_rd[g] || a_tgt_wr[4*g +: 4] != 0) && a_tgt_accept[g])
          q.push_back('{cyc + dly_a, a_tgt_reqtag[11*g +: 11], a_tgt_addr[32*g +: 32]});
      end
    end
    always @(posedge clk) begin
      #1;
      ack_r = rst_n && !stall_a && q.size() > 0 && q[0].due <= cyc;
      data_r = ack_r ? (q[0].addr ^ tgt_key(g)) : 32'h0;
      tag_r = ack_r ? q[0].tag : 11'h0;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_rb
    ent_t q[$];
    logic ack_r = 1'b0;
    logic [31:0] data_r = '0;
    logic [10:0] tag_r = '0;
    assign b_tgt_ack[g] = ack_r;
    assign b_tgt_err[g] = 1'b0;
    assign b_tgt_rdata[32*g +: 32] = data_r;
    assign b_tgt_rtag[11*g +: 11] = tag_r;
    always @(negedge clk) begin
      if (!rst_n) q.delete();
      else begin
        if (ack_r) void'(q.pop_front());
        if ((b_tgt_rd[g] || b_tgt_wr[4*g +: 4] != 0) && b_tgt_accept[g])
          q.push_back('{cyc + dly_b, b_tgt_reqtag[11*g +: 11], b_tgt_addr[32*g +: 32]});
      end
    end
    always @(posedge clk) begin
      #1;
      ack_r = rst_n && !stall_b && q.size() > 0 && q[0].due <= cyc;
      data_r = ack_r ? (q[0].addr ^ tgt_key(g)) : 32'h0;
      tag_r = ack_r ? q[0].tag : 11'h0;
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {error, data, tag}
  logic [43:0] exp_a[$];
  logic [43:0] exp_b[$];

  always @(negedge clk) begin
    if (rst_n && a_ack) begin
      n_tests++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_ack got err=%0b data=%h tag=%h", a_error, a_data, a_rtag);
      end else begin
        logic [43:0] e;
        e = exp_a.pop_front();
        if ({a_error, a_data, a_rtag} !== e) begin
          n_fail++;
          $display("FAIL a_resp got err=%0b data=%h tag=%h exp err=%0b data=%h tag=%h",
                   a_error, a_data, a_rtag, e[43], e[42:11], e[10:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_ack) begin
      n_tests++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_ack got err=%0b data=%h tag=%h", b_error, b_data, b_rtag);
      end else begin
        logic [43:0] e;
        e = exp_b.pop_front();
        if ({b_error, b_data, b_rtag} !== e) begin
          n_fail++;
          $display("FAIL b_resp got err=%0b data=%h tag=%h exp err=%0b data=%h tag=%h",
                   b_error, b_data, b_rtag, e[43], e[42:11], e[10:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic acc_now(input int which);
    return (which == 0) ? a_accept : b_accept;
  endfunction

  function automatic logic [3:0] rd_now(input int which);
    return (which == 0) ? {2'b00, a_tgt_rd} : {1'b0, b_tgt_rd};
  endfunction

  function automatic logic [15:0] wr_now(input int which);
    return (which == 0) ? {8'h00, a_tgt_wr} : {4'h0, b_tgt_wr};
  endfunction

  // Issue one request (called just after a rising edge); tgt < 0 means decode error.
  task automatic send(input int which, input logic [31:0] addr, input logic [3:0] wr,
                      input logic [10:0] tag, input int tgt,
                      output int waited, output logic [3:0] rd_seen, output logic [15:0] wr_seen);
    logic [43:0] e;
    logic leak;
    e = (tgt < 0) ? {1'b1, 32'h0, tag} : {1'b0, addr ^ tgt_key(tgt), tag};
    if (which == 0) exp_a.push_back(e); else exp_b.push_back(e);
    addr_i = addr; wdata_i = ~addr; tag_i = tag;
    if (which == 0) begin rd_a = (wr == 4'h0); wr_a = wr; end
    else begin rd_b = (wr == 4'h0); wr_b = wr; end
    waited = 0;
    leak = 1'b0;
    @(negedge clk);
    while (!acc_now(which) && waited < 40) begin
      if (rd_now(which) != 0 || wr_now(which) != 0) leak = 1'b1;
      waited++;
      @(negedge clk);
    end
    rd_seen = rd_now(which);
    wr_seen = wr_now(which);
    check($sformatf("accept_tag_%0h", tag), {63'h0, acc_now(which)}, 64'h1);
    check("hold_gates_strobes", {63'h0, leak}, 64'h0);
    @(posedge clk);
    #1;
    rd_a = 1'b0; wr_a = 4'h0; rd_b = 1'b0; wr_b = 4'h0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_all_acked", 64'(exp_a.size() + exp_b.size()), 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  logic [31:0] va_addr[4] = '{32'h0000_FFFC, 32'h0001_0000, 32'h8000_0040, 32'h0000_0008};
  logic [3:0]  va_wr[4]   = '{4'h0, 4'h0, 4'hF, 4'h3};
  int          va_tgt[4]  = '{0, 1, 1, 0};
  logic [15:0] va_rd[4]   = '{16'h1, 16'h2, 16'h0, 16'h0};
  logic [15:0] va_wrs[4]  = '{16'h0, 16'h0, 16'h00F0, 16'h0003};

  logic [31:0] vb_addr[4] = '{32'h1000_0000, 32'h2000_0004, 32'h3000_0000, 32'h0000_1234};
  int          vb_tgt[4]  = '{1, 2, -1, 0};
  logic [15:0] vb_rd[4]   = '{16'h2, 16'h4, 16'h0, 16'h1};

  initial begin
    int w;
    int w4;
    logic [3:0] r;
    logic [15:0] ws;

    // reset state
    addr_i = 32'hDEAD_BEEF;
    tag_i = 11'h5A5;
    repeat (3) @(negedge clk);
    check("rst_a_accept", {63'h0, a_accept}, 64'h0);
    check("rst_a_ack", {63'h0, a_ack}, 64'h0);
    check("rst_a_tgt_rd", {62'h0, a_tgt_rd}, 64'h0);
    check("rst_a_pend", 64'(dut_a.pend_q), 64'h0);
    check("rst_b_pend_tgt", {56'h0, 3'(dut_b.tgt_q), 3'h0, 2'(dut_b.pend_q)}, 64'h0);
    check("rst_a_bcast_addr", a_tgt_addr, {2{32'hDEAD_BEEF}});
    check("rst_b_bcast_tag", {31'h0, b_tgt_reqtag}, {31'h0, {3{11'h5A5}}});
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // decode table on A: reads and writes to each target
    for (int i = 0; i < 4; i++) begin
      send(0, va_addr[i], va_wr[i], 11'h050 + 11'(i), va_tgt[i], w, r, ws);
      check($sformatf("a_vec%0d_wait", i), 64'(w), 64'h0);
      check($sformatf("a_vec%0d_rd", i), {60'h0, r}, {48'h0, va_rd[i]});
      check($sformatf("a_vec%0d_wr", i), {48'h0, ws}, {48'h0, va_wrs[i]});
      drain();
    end

    // target switch while tgt0 pending: held until tgt0 ack
    dly_a = 4;
    send(0, 32'h0000_0100, 4'h0, 11'h001, 0, w, r, ws);
    check("t1_first_rd", {60'h0, r}, 64'h1);
    send(0, 32'h8000_0000, 4'h0, 11'h002, 1, w, r, ws);
    check("t1_switch_wait", 64'(w), 64'h4);
    check("t1_switch_rd", {60'h0, r}, 64'h2);
    drain();

    // four outstanding reads to tgt0
    for (int i = 0; i < 4; i++) begin
      send(0, 32'h0000_0010, 4'h0, 11'(i), 0, w, r, ws);
      check($sformatf("t2_wait%0d", i), 64'(w), 64'h0);
      check($sformatf("t2_pend%0d", i), 64'(dut_a.pend_q), 64'(i + 1));
    end
    drain();
    check("t2_pend_zero", 64'(dut_a.pend_q), 64'h0);

    // accept and ack in the same cycle
    dly_a = 1;
    send(0, 32'h0000_0020, 4'h0, 11'h030, 0, w, r, ws);
    send(0, 32'h0000_0024, 4'h0, 11'h031, 0, w, r, ws);
    check("t3_no_hold", 64'(w), 64'h0);
    check("t3_pend_same", 64'(dut_a.pend_q), 64'h1);
    drain();

    // decode table on B including an unmapped address
    for (int i = 0; i < 4; i++) begin
      send(1, vb_addr[i], 4'h0, 11'h201 + 11'(i), vb_tgt[i], w, r, ws);
      check($sformatf("b_vec%0d_wait", i), 64'(w), 64'h0);
      check($sformatf("b_vec%0d_rd", i), {60'h0, r}, {48'h0, vb_rd[i]});
      drain();
    end

    // outstanding limit 3 on B
    stall_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1, 32'h0000_0040, 4'h0, 11'h010 + 11'(i), 0, w, r, ws);
      check($sformatf("t4_wait%0d", i), 64'(w), 64'h0);
    end
    check("t4_pend_full", 64'(dut_b.pend_q), 64'h3);
    fork
      send(1, 32'h0000_0044, 4'h0, 11'h013, 0, w4, r, ws);
      begin
        repeat (6) @(negedge clk);
        check("t4_held_accept", {63'h0, b_accept}, 64'h0);
        stall_b = 1'b0;
      end
    join
    check("t4_limit_wait", 64'(w4), 64'h7);
    drain();

    // error responder: next-cycle ack, then back-to-back errors
    send(1, 32'hF000_0000, 4'h0, 11'h123, -1, w, r, ws);
    check("t5_wait", 64'(w), 64'h0);
    @(negedge clk);
    check("t5_ack_next", {52'h0, b_ack, b_error, 32'(b_data) == 0, b_rtag},
          {52'h0, 1'b1, 1'b1, 1'b1, 11'h123});
    @(posedge clk);
    #1;
    send(1, 32'hF000_0010, 4'h0, 11'h124, -1, w, r, ws);
    send(1, 32'hF000_0020, 4'h0, 11'h125, -1, w, r, ws);
    check("t5_b2b_wait", 64'(w), 64'h0);
    drain();

    // reset with two requests outstanding on tgt1
    stall_a = 1'b1;
    send(0, 32'h8000_0200, 4'h0, 11'h060, 1, w, r, ws);
    send(0, 32'h8000_0204, 4'h0, 11'h061, 1, w, r, ws);
    check("t6_pend_two", 64'(dut_a.pend_q), 64'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_pend_cleared", 64'(dut_a.pend_q), 64'h0);
    check("t6_tgt_cleared", 64'(dut_a.tgt_q), 64'h0);
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_a = 1'b0;
    @(posedge clk);
    #1;
    send(0, 32'h8000_0300, 4'h0, 11'h062, 1, w, r, ws);
    check("t6_post_rst_wait", 64'(w), 64'h0);
    check("t6_post_rst_rd", {60'h0, r}, 64'h2);
    drain();

    check("final_queues_empty", 64'(exp_a.size() + exp_b.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
